// File: rtl/dsm_pkg.sv
// Shared types and defaults for the delta-sigma conversion sequencer.
package dsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_INTEG,
    ST_DUMP,
    ST_CAPT,
    ST_RUN
  } state_t;

  localparam logic MODE_INCR = 1'b0;
  localparam logic MODE_REG  = 1'b1;

  localparam int DEFAULT_M           = 16;
  localparam int DEFAULT_WARMUP      = 2;
  localparam int DEFAULT_OUTPUT_BITS = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dsm_result_buffer.sv
// Single-entry valid/ready result holding register with sticky overrun flag.
// Optional saturating drop counter enabled by DSM_SEQ_OVERRUN_CNT_EN.
module dsm_result_buffer
  import dsm_pkg::*;
#(
  parameter int W = DEFAULT_OUTPUT_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         capture,
  input  logic [W-1:0] data,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         overrun,
  output logic [7:0]   overrun_cnt
);

  logic [W-1:0] data_reg;
  logic         valid_reg;
  logic         overrun_reg;
  logic         drop;

  // A pending result blocks the new one unless it is being accepted this cycle.
  assign drop = capture && valid_reg && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (capture && !drop) begin
        data_reg  <= data;
        valid_reg <= 1'b1;
      end else if (valid_reg && out_ready) begin
        valid_reg <= 1'b0;
      end
      if (clear) begin
        overrun_reg <= 1'b0;
      end else if (drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

`ifdef DSM_SEQ_OVERRUN_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_reg <= 8'd0;
    end else if (clear) begin
      drop_cnt_reg <= 8'd0;
    end else if (drop) begin
      drop_cnt_reg <= sat_inc8(drop_cnt_reg);
    end
  end

  assign overrun_cnt = drop_cnt_reg;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/dsm_conversion_sequencer.sv
// Sequences the CIC decimator for incremental (fixed-length) and regular (framed) modes.
// Build option DSM_SEQ_OVERRUN_CNT_EN adds the dropped-result counter.
module dsm_conversion_sequencer
  import dsm_pkg::*;
#(
  parameter int OUTPUT_BITS = DEFAULT_OUTPUT_BITS,
  parameter int OSR_W       = 8,
  parameter int M           = DEFAULT_M,
  parameter int WARMUP      = DEFAULT_WARMUP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic                   continuous,
  input  logic [OSR_W-1:0]       osr,
  input  logic [OUTPUT_BITS-1:0] flt_z,
  output logic                   flt_global_reset,
  output logic                   flt_reset,
  output logic                   flt_type_dec,
  output logic [OUTPUT_BITS-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             overrun_cnt
);

  localparam int FRAME_W = (M > 1) ? $clog2(M) : 1;
  localparam int WARM_W  = $clog2(WARMUP + 2);

  localparam logic [OSR_W-1:0]   OSR_MIN    = OSR_W'(2);
  localparam logic [OSR_W-1:0]   OSR_ONE    = OSR_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(M - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [WARM_W-1:0]  WARM_DONE  = WARM_W'(WARMUP);
  localparam logic [WARM_W-1:0]  WARM_ONE   = WARM_W'(1);

  state_t             state_reg, state_next;
  logic               mode_reg;
  logic               continuous_reg;
  logic [OSR_W-1:0]   osr_reg;
  logic [OSR_W-1:0]   cnt_reg;
  logic               stop_reg;
  logic [FRAME_W-1:0] frame_reg;
  logic               cap_pend_reg;
  logic [WARM_W-1:0]  warm_reg;

  logic stop_seen;
  logic capture;
  logic start_accept;

  assign stop_seen    = stop_reg || stop;
  assign start_accept = (state_reg == ST_IDLE) && start;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_INIT;
      ST_INIT:  state_next = (mode_reg == MODE_REG) ? ST_RUN : ST_INTEG;
      ST_INTEG: if (cnt_reg == osr_reg - OSR_ONE) state_next = ST_DUMP;
      ST_DUMP:  state_next = ST_CAPT;
      ST_CAPT: begin
        capture    = 1'b1;
        state_next = (!continuous_reg || stop_seen) ? ST_IDLE : ST_INTEG;
      end
      ST_RUN: begin
        // Capture slot is the cycle after a frame boundary; warm-up frames are discarded.
        if (cap_pend_reg) begin
          capture = (warm_reg == WARM_DONE);
          if (stop_seen) state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= 1'b0;
      continuous_reg <= 1'b0;
      osr_reg        <= '0;
      cnt_reg        <= '0;
      stop_reg       <= 1'b0;
      frame_reg      <= '0;
      cap_pend_reg   <= 1'b0;
      warm_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        mode_reg       <= mode;
        continuous_reg <= continuous;
        osr_reg        <= (osr < OSR_MIN) ? OSR_MIN : osr;
      end
      if (state_next == ST_IDLE) begin
        stop_reg <= 1'b0;
      end else if (stop && state_reg != ST_IDLE) begin
        stop_reg <= 1'b1;
      end
      case (state_reg)
        ST_INIT: begin
          cnt_reg      <= '0;
          frame_reg    <= '0;
          cap_pend_reg <= 1'b0;
          warm_reg     <= '0;
        end
        ST_INTEG: cnt_reg <= (state_next == ST_DUMP) ? '0 : cnt_reg + OSR_ONE;
        ST_RUN: begin
          frame_reg    <= (frame_reg == FRAME_LAST) ? '0 : frame_reg + FRAME_ONE;
          cap_pend_reg <= (frame_reg == FRAME_LAST);
          if (cap_pend_reg && warm_reg != WARM_DONE) warm_reg <= warm_reg + WARM_ONE;
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state_reg != ST_IDLE);
  assign flt_global_reset = (state_reg == ST_INIT);
  assign flt_reset        = (state_reg == ST_DUMP);
  assign flt_type_dec     = mode_reg;

  dsm_result_buffer #(
    .W(OUTPUT_BITS)
  ) u_result_buffer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .capture    (capture),
    .data       (flt_z),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .overrun_cnt(overrun_cnt)
  );

endmodule

// File: tb/tb_dsm_conversion_sequencer.sv
// Scoreboard bench for dsm_conversion_sequencer with a behavioural CIC2 filter model fed X=1.
module tb_dsm_conversion_sequencer;
  import dsm_pkg::*;

  localparam int OB = 16;
  localparam int OW = 8;
  localparam int MM = 16;
  localparam int WU = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic          continuous = 1'b0;
  logic          out_ready = 1'b1;
  logic [OW-1:0] osr = '0;
  logic [OB-1:0] flt_z;
  logic [OB-1:0] out_data;
  logic          flt_global_reset, flt_reset, flt_type_dec;
  logic          out_valid, busy, overrun;
  logic [7:0]    overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;
  exp_t sb[$];

  dsm_conversion_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .mode            (mode),
    .continuous      (continuous),
    .osr             (osr),
    .flt_z           (flt_z),
    .flt_global_reset(flt_global_reset),
    .flt_reset       (flt_reset),
    .flt_type_dec    (flt_type_dec),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .overrun         (overrun),
    .overrun_cnt     (overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural second-order CIC with constant input 1.
  logic [15:0] i1 = '0, i2 = '0, z = '0, i2_prev = '0, d1_prev = '0;
  int fcnt = 0;
  assign flt_z = z;

  always @(posedge clk) begin
    if (flt_global_reset) begin
      i1 <= '0; i2 <= '0; z <= '0; i2_prev <= '0; d1_prev <= '0; fcnt <= 0;
    end else if (flt_type_dec == MODE_INCR) begin
      if (flt_reset) begin
        z <= i2; i1 <= '0; i2 <= '0;
      end else begin
        i1 <= i1 + 16'd1; i2 <= i2 + i1;
      end
    end else begin
      i1 <= i1 + 16'd1; i2 <= i2 + i1;
      if (fcnt == MM - 1) begin
        fcnt    <= 0;
        i2_prev <= i2 + i1;
        d1_prev <= (i2 + i1) - i2_prev;
        z       <= ((i2 + i1) - i2_prev) - d1_prev;
      end else begin
        fcnt <= fcnt + 1;
      end
    end
  end

  // Reference values: second integrator after n unit samples is n(n-1)/2.
  function automatic int i2_of(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int reg_value(input int j);
    int d1, d0;
    d1 = i2_of(j * MM) - i2_of((j - 1) * MM);
    d0 = (j > 1) ? i2_of((j - 1) * MM) - i2_of((j - 2) * MM) : 0;
    return (d1 - d0) & 16'hFFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0d, expected no result (cycle %0d)", out_data, cyc);
      end else begin
        e = sb.pop_front();
        check("result_data", 32'(out_data), e.val);
        if (e.cyc >= 0) check("result_cycle", cyc, e.cyc);
        $display("[TB] result %0d at cycle %0d", out_data, cyc);
      end
    end
  end

  task automatic sb_push(input int r, input int v, input int at, input int rdy_mode);
    exp_t e;
    e.val = v;
    e.cyc = (rdy_mode == 0 || (rdy_mode == 2 && r > 0)) ? at : -1;
    if (rdy_mode != 1 || r == 0) sb.push_back(e);
  endtask

  // rdy_mode: 0 ready always, 1 ready held low, 2 ready rises on the second capture.
  task automatic run_txn(input logic m, input int osr_in, input logic cont,
                         input int stop_at, input int rdy_mode);
    int c0, oe, last_cap, nres, second_cap, first_val, k, j, v, exp_cnt;
    bit done, is_dump;
    oe = (osr_in < 2) ? 2 : osr_in;
    nres = 0; second_cap = -1; first_val = 0; last_cap = 0;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1; mode = m; osr = OW'(osr_in); continuous = cont; stop = 1'b0;
    out_ready = (rdy_mode == 0);
    if (m == MODE_INCR) begin
      k = 0;
      forever begin
        last_cap = oe + 3 + k * (oe + 2);
        v = i2_of((k > 0) ? oe + 1 : oe) & 16'hFFFF;
        sb_push(nres, v, c0 + last_cap + 1, rdy_mode);
        if (nres == 0) first_val = v;
        if (nres == 1) second_cap = last_cap;
        nres++;
        if (!cont || (stop_at > 0 && stop_at <= last_cap)) break;
        k++;
      end
    end else begin
      j = 1;
      forever begin
        last_cap = 2 + j * MM;
        if (j > WU) begin
          sb_push(nres, reg_value(j), c0 + last_cap + 1, rdy_mode);
          nres++;
        end
        if (stop_at <= last_cap) break;
        j++;
      end
    end
    $display("[TB] txn mode=%0d osr=%0d cont=%0d stop_at=%0d rdy_mode=%0d results=%0d",
             m, osr_in, cont, stop_at, rdy_mode, nres);
    done = 1'b0;
    for (int t = 1; t <= 3000 && !done; t++) begin
      @(posedge clk); #1;
      start      = (t == 3);
      stop       = (t == stop_at);
      mode       = 1'($urandom);
      continuous = 1'($urandom);
      osr        = OW'($urandom);
      out_ready  = (rdy_mode == 0) || (rdy_mode == 2 && t >= second_cap);
      if (busy == 1'b0) begin
        done = 1'b1;
        check("end_cycle", t, last_cap + 1);
      end else begin
        is_dump = (m == MODE_INCR) && (t >= oe + 2) && (((t - oe - 2) % (oe + 2)) == 0);
        check("ctrl_outputs", {busy, flt_global_reset, flt_reset, flt_type_dec},
              {1'b1, (t == 1), is_dump, m});
      end
    end
    start = 1'b0; stop = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: busy still 1 after 3000 cycles, expected 0");
    end
    repeat (2) @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      check("held_data", 32'(out_data), first_val);
      check("held_valid", 32'(out_valid), 1);
    end
    check("overrun", 32'(overrun), (rdy_mode == 1 && nres >= 2) ? 1 : 0);
`ifdef DSM_SEQ_OVERRUN_CNT_EN
    exp_cnt = (rdy_mode == 1 && nres >= 2) ? ((nres - 1 > 255) ? 255 : nres - 1) : 0;
`else
    exp_cnt = 0;
`endif
    check("overrun_cnt", 32'(overrun_cnt), exp_cnt);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
  endtask

  initial begin
    int m, oi, ct, sa, oe;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, out_valid, overrun, flt_global_reset, flt_reset,
                            flt_type_dec, out_data, overrun_cnt}, 0);
    reset = 1'b0;

    run_txn(MODE_INCR, 10, 1'b0, 0, 0);   // single conversion: 45
    run_txn(MODE_INCR, 4, 1'b1, 15, 0);   // continuous, stop in third conversion
    run_txn(MODE_REG, 0, 1'b0, 85, 0);    // regular, warm-up frames hidden
    run_txn(MODE_INCR, 0, 1'b0, 0, 0);    // osr clamped to 2
    run_txn(MODE_INCR, 1, 1'b0, 0, 0);
    run_txn(MODE_INCR, 4, 1'b1, 10, 1);   // two captures, ready low: overrun
    run_txn(MODE_INCR, 4, 1'b1, 10, 2);   // capture coincides with handshake

    // Asynchronous reset in the middle of integration.
    @(posedge clk); #1;
    start = 1'b1; mode = MODE_INCR; osr = OW'(10); continuous = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {busy, out_valid, overrun, flt_global_reset, flt_reset,
                                  flt_type_dec, out_data, overrun_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_txn(MODE_INCR, 10, 1'b0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      m  = $urandom_range(0, 1);
      oi = $urandom_range(0, 20);
      ct = $urandom_range(0, 1);
      oe = (oi < 2) ? 2 : oi;
      if (m == 1) sa = $urandom_range(1, 100);
      else if (ct == 1) sa = $urandom_range(1, 3 * (oe + 2) + 6);
      else sa = $urandom_range(0, 30);
      run_txn(1'(m), oi, 1'(ct), sa, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
